// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// The result is always carried as a 3-bit {lt, gt, eq} code.
package serial_mag_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  function automatic int cmp_idx_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_mag_comparator_cmp_bit.sv
// Combinational 1-bit comparator cell.
// Exactly one of lt/gt/eq is high for any pair of input bits.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt,
  output logic eq
);

  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Word magnitude comparator built from one bit cell, scanning MSB-first
// one bit per clock, with optional early exit on the first differing bit.
//
// state | meaning
// IDLE  | waiting for start, last result held
// SCAN  | comparing a_q[idx_q] against b_q[idx_q]
// DONE  | result valid, done pulse, start accepted back-to-back
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit SIGNED     = 1'b0,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int IDX_W = cmp_idx_w(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       res_q, res_d;
  logic             load;
  logic             cell_lt, cell_gt, cell_eq;
  logic [2:0]       bit_res;

  cmp_bit_cell u_cell (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .lt (cell_lt),
    .gt (cell_gt),
    .eq (cell_eq)
  );

  // In signed mode a set sign bit means the smaller value, so lt/gt swap there.
  always_comb begin
    bit_res = RES_NONE;
    if (!cell_eq) begin
      if (SIGNED && (idx_q == IDX_MSB)) bit_res = {cell_gt, cell_lt, 1'b0};
      else                              bit_res = {cell_lt, cell_gt, 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    res_d   = res_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = IDX_MSB;
          pend_d  = RES_NONE;
          res_d   = RES_NONE;
          state_d = SCAN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // The first difference is frozen in pend; later bits cannot override it.
        if ((pend_q == RES_NONE) && (bit_res != RES_NONE)) pend_d = bit_res;
        if (EARLY_EXIT && (pend_d != RES_NONE)) begin
          res_d   = pend_d;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = (pend_d == RES_NONE) ? RES_EQ : pend_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pend_q  <= RES_NONE;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      if (load) begin
        a_q <= a_in;
        b_q <= b_in;
      end
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign lt    = res_q[2];
  assign gt    = res_q[1];
  assign eq    = res_q[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: three configurations (unsigned early-exit,
// unsigned full-scan, signed early-exit) against an arithmetic reference.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic [7:0] a_in  [3];
  logic [7:0] b_in  [3];
  logic       ready [3];
  logic       busy  [3];
  logic       done  [3];
  logic       lt    [3];
  logic       gt    [3];
  logic       eq    [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_ue (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .lt(lt[0]), .gt(gt[0]), .eq(eq[0]));

  serial_mag_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_uf (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .lt(lt[1]), .gt(gt[1]), .eq(eq[1]));

  serial_mag_comparator #(.WIDTH(8), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u_se (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_in(a_in[2]), .b_in(b_in[2]),
    .ready(ready[2]), .busy(busy[2]), .done(done[2]), .lt(lt[2]), .gt(gt[2]), .eq(eq[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: instance 2 is signed, instance 1 never exits early.
  function automatic logic [2:0] model_res(input int k, input logic [7:0] a, input logic [7:0] b);
    int av, bv;
    av = (k == 2) ? int'($signed(a)) : int'(a);
    bv = (k == 2) ? int'($signed(b)) : int'(b);
    return {av < bv, av > bv, av == bv};
  endfunction

  function automatic int model_lat(input int k, input logic [7:0] a, input logic [7:0] b);
    if (k == 1 || a == b) return 8;
    for (int j = 7; j >= 0; j--)
      if (a[j] != b[j]) return 8 - j;
    return 8;
  endfunction

  // Drives start for exactly the current cycle; returns at the negedge after acceptance.
  task automatic launch(input int k, input logic [7:0] a, input logic [7:0] b);
    start[k] = 1'b1;
    a_in[k]  = a;
    b_in[k]  = b;
    @(negedge clk);
    start[k] = 1'b0;
    check($sformatf("busy_after_accept[%0d]", k), 32'(busy[k]), 32'd1);
    check($sformatf("ready_after_accept[%0d]", k), 32'(ready[k]), 32'd0);
    check($sformatf("done_after_accept[%0d]", k), 32'(done[k]), 32'd0);
    check($sformatf("res_cleared[%0d]", k), 32'({lt[k], gt[k], eq[k]}), 32'd0);
  endtask

  task automatic wait_done(input int k, input logic [7:0] a, input logic [7:0] b);
    int cyc = 0;
    while (done[k] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency[%0d] a=%0h b=%0h", k, a, b), 32'(cyc), 32'(model_lat(k, a, b)));
    check($sformatf("result[%0d] a=%0h b=%0h", k, a, b), 32'({lt[k], gt[k], eq[k]}),
          32'(model_res(k, a, b)));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_ready[%0d]", tag, k), 32'(ready[k]), 32'd1);
      check($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 32'd0);
      check($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 32'd0);
      check($sformatf("%s_res[%0d]", tag, k), 32'({lt[k], gt[k], eq[k]}), 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b1;
      a_in[k]  = 8'h5A;
      b_in[k]  = 8'hA5;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with start high: nothing may leave IDLE.
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    launch(0, 8'h80, 8'h7F); wait_done(0, 8'h80, 8'h7F);
    @(negedge clk);
    launch(0, 8'h12, 8'h13); wait_done(0, 8'h12, 8'h13);
    @(negedge clk);
    launch(1, 8'hF0, 8'h0F); wait_done(1, 8'hF0, 8'h0F);
    @(negedge clk);
    launch(2, 8'h80, 8'h01); wait_done(2, 8'h80, 8'h01);
    @(negedge clk);
    launch(2, 8'hFF, 8'hFE); wait_done(2, 8'hFF, 8'hFE);
    @(negedge clk);
    launch(2, 8'hA5, 8'hA5); wait_done(2, 8'hA5, 8'hA5);

    // Result holds through the return to IDLE.
    @(negedge clk);
    check("hold_in_idle_eq", 32'(eq[2]), 32'd1);
    check("hold_in_idle_ready", 32'(ready[2]), 32'd1);

    // start held during SCAN with other operands must be ignored.
    @(negedge clk);
    launch(1, 8'h01, 8'h02);
    start[1] = 1'b1;
    a_in[1]  = 8'hFF;
    b_in[1]  = 8'h00;
    wait_done(1, 8'h01, 8'h02);
    start[1] = 1'b0;

    // Back-to-back: start in the DONE cycle launches with no idle gap.
    @(negedge clk);
    launch(0, 8'h40, 8'h41); wait_done(0, 8'h40, 8'h41);
    launch(0, 8'hC3, 8'h3C); wait_done(0, 8'hC3, 8'h3C);
    launch(0, 8'h77, 8'h77); wait_done(0, 8'h77, 8'h77);

    // Randomized against the reference; some runs chained back-to-back.
    for (int i = 0; i < 60; i++) begin
      int         k;
      logic [7:0] ra, rb;
      k  = $urandom_range(0, 2);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      if (ready[k] !== 1'b1) @(negedge clk);
      launch(k, ra, rb);
      wait_done(k, ra, rb);
    end

    // Async reset three bits into a full scan aborts it with no done pulse.
    @(negedge clk);
    launch(0, 8'h55, 8'h55);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done[0]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(0, 8'h3C, 8'h3D); wait_done(0, 8'h3C, 8'h3D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
